pipeline_ctrl: RTL

Central pipeline controller that produces the `ctrl` bundle (pause vector, exception/branch flush) consumed by every inter-stage register, including the dispatch→ex register.
- Resolves per-stage stall requests into a monotone pause prefix.
- Prioritises exception, ertn, interrupt and branch redirects.
- Sequences the IDLE low-power wait.
- Keeps stall/flush performance counters and a stall watchdog.

---
 rtl/pipeline_ctrl.sv | 135 +++++++++++++
 1 files changed

// File: rtl/pipeline_ctrl.sv
// Central pipeline controller: turns per-stage stall requests into a prefix pause
// vector, arbitrates exception/branch flushes, sequences IDLE and keeps stall stats.
module pipeline_ctrl #(
    parameter int NUM_STAGES = 8,
    parameter int EX_STAGE   = 5,
    parameter int WDOG_LIMIT = 1024,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NUM_STAGES-1:0] pause_req,
    input  logic                  excp_req,
    input  logic                  ertn_req,
    input  logic                  idle_req,
    input  logic                  int_pending,
    input  logic                  branch_req,
    output logic [NUM_STAGES-1:0] pause,
    output logic                  exception_flush,
    output logic                  branch_flush,
    output logic                  in_idle,
    output logic [CNT_W-1:0]      stall_cycles,
    output logic [CNT_W-1:0]      flush_count,
    output logic                  hang_err
);

    localparam int WDOG_W = (WDOG_LIMIT > 2) ? $clog2(WDOG_LIMIT) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_LIMIT - 1);

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_IDLE = 1'b1
    } state_t;

    state_t                  state_reg;
    state_t                  state_next;
    logic [CNT_W-1:0]        stall_reg;
    logic [CNT_W-1:0]        stall_next;
    logic [CNT_W-1:0]        flush_reg;
    logic [CNT_W-1:0]        flush_next;
    logic [WDOG_W-1:0]       wdog_reg;
    logic [WDOG_W-1:0]       wdog_next;
    logic                    hang_reg;
    logic                    hang_next;

    logic [NUM_STAGES-1:0]   stall_prefix;
    logic [NUM_STAGES-1:0]   pause_int;
    logic                    exc_int;
    logic                    br_int;

    // A stall at stage i must also freeze every older stage, so each bit is the
    // OR of its own request and all younger ones.
    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_prefix
            assign stall_prefix[gi] = |pause_req[NUM_STAGES-1:gi];
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        pause_int  = '0;
        exc_int    = 1'b0;
        br_int     = 1'b0;
        case (state_reg)
            ST_RUN: begin
                exc_int = excp_req | ertn_req;
                if (!exc_int) begin
                    pause_int = stall_prefix;
                    br_int    = branch_req & ~stall_prefix[EX_STAGE];
                    if (idle_req && !stall_prefix[EX_STAGE]) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_IDLE: begin
                // Only an interrupt wakes the core; wb commits cannot happen while frozen.
                exc_int = int_pending;
                if (int_pending) begin
                    state_next = ST_RUN;
                end else begin
                    pause_int = '1;
                end
            end
            default: begin
                state_next = ST_RUN;
            end
        endcase
    end

    always_comb begin
        stall_next = stall_reg;
        flush_next = flush_reg;
        wdog_next  = '0;
        hang_next  = hang_reg;
        if (|pause_int) begin
            stall_next = stall_reg + CNT_W'(1);
        end
        if (exc_int) begin
            flush_next = flush_reg + CNT_W'(1);
        end
        if (pause_int[0] && (state_reg == ST_RUN)) begin
            if (wdog_reg == WDOG_LAST) begin
                hang_next = 1'b1;
                wdog_next = wdog_reg;
            end else begin
                wdog_next = wdog_reg + WDOG_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_RUN;
            stall_reg <= '0;
            flush_reg <= '0;
            wdog_reg  <= '0;
            hang_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            stall_reg <= stall_next;
            flush_reg <= flush_next;
            wdog_reg  <= wdog_next;
            hang_reg  <= hang_next;
        end
    end

    // Stage registers see a quiet ctrl bundle while reset is asserted.
    assign pause           = rst_n ? pause_int : '0;
    assign exception_flush = rst_n & exc_int;
    assign branch_flush    = rst_n & br_int;
    assign in_idle         = (state_reg == ST_IDLE);
    assign stall_cycles    = stall_reg;
    assign flush_count     = flush_reg;
    assign hang_err        = hang_reg;

endmodule
